sd_dma_seq: RTL and testbench

- Multi-block sequencer for the SD DMA nibble-capture engine.
- Accepts one MCU command: block count, first-block start position, last-block end position. Issues one DMA start per 512-byte block and applies partial and mid-block qualifiers to the first and last blocks only.
- Inserts a programmable inter-block gap and supervises each block with arm and run timeouts.
- Reports busy, done, error and the remaining block count back to the MCU register file.

---
 rtl/sd_dma_seq.sv | 223 ++++++++++++++++++++++
 tb/tb_sd_dma_seq.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_dma_seq.sv
// sd_dma_seq: multi-block sequencer for the SD DMA nibble-capture engine.
// Takes one MCU command, issues one level-held DMA_EN per 512-byte block,
// qualifies the first and last blocks, inserts an inter-block gap and
// supervises each block with arm and run timeouts.
//
// Debug: STATE_DBG exposes the FSM state encoding
//   0 IDLE, 1 SETUP, 2 ARM, 3 RUN, 4 GAP, 5 WAIT_IDLE, 6 FINISH.
//
// Engine handshake: DMA_EN is a level-held request that stays high for
// EN_WIDTH cycles; the engine acknowledges by raising DMA_STATUS and
// signals the end of the block by lowering it. Qualifiers are stable for
// at least two cycles before DMA_EN rises and until the block leaves RUN.
module sd_dma_seq #(
    parameter int GAP_CYCLES  = 16,
    parameter int EN_WIDTH    = 4,
    parameter int ARM_TIMEOUT = 64,
    parameter int RUN_TIMEOUT = 4400
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CMD_START,
    input  logic        CMD_ABORT,
    input  logic [15:0] CMD_BLKCNT,
    input  logic [10:0] CMD_START_POS,
    input  logic [10:0] CMD_END_POS,
    input  logic        CMD_MID_START,
    input  logic        CMD_MID_END,
    input  logic        DMA_STATUS,
    output logic        DMA_EN,
    output logic        DMA_PARTIAL,
    output logic [10:0] DMA_PARTIAL_START,
    output logic [10:0] DMA_PARTIAL_END,
    output logic        DMA_START_MID_BLOCK,
    output logic        DMA_END_MID_BLOCK,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR,
    output logic [15:0] BLOCKS_LEFT,
    output logic [2:0]  STATE_DBG
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SETUP     = 3'd1,
        S_ARM       = 3'd2,
        S_RUN       = 3'd3,
        S_GAP       = 3'd4,
        S_WAIT_IDLE = 3'd5,
        S_FINISH    = 3'd6
    } state_t;

    // SETUP registers the qualifiers in its first cycle, then settles two
    // more cycles so they lead DMA_EN by two cycles.
    localparam logic [12:0] SETTLE_LAST = 13'd2;
    localparam logic [12:0] GAP_LAST    = 13'(GAP_CYCLES - 1);
    // DONE registers out of FINISH, so ARM is left two cycles early to put
    // DONE exactly ARM_TIMEOUT cycles after the DMA_EN rise.
    localparam logic [12:0] ARM_LAST    = 13'(ARM_TIMEOUT - 2);
    localparam logic [12:0] RUN_LAST    = 13'(RUN_TIMEOUT - 1);
    localparam logic [7:0]  EN_LAST     = 8'(EN_WIDTH - 1);
    localparam logic [10:0] FULL_POS    = 11'd1024;

    state_t      state_q;
    logic [12:0] tmr_q;
    logic [12:0] tmr_d;
    logic [7:0]  en_cnt_q;
    logic        en_q;
    logic        partial_q;
    logic [10:0] pstart_q;
    logic [10:0] pend_q;
    logic        start_mid_q;
    logic        end_mid_q;
    logic        busy_q;
    logic        done_q;
    logic        err_q;
    logic [15:0] blkcnt_q;
    logic [15:0] blocks_left_q;
    logic [10:0] start_pos_q;
    logic [10:0] end_pos_q;
    logic        mid_start_q;
    logic        mid_end_q;
    logic        first_d;
    logic        last_d;
    logic        partial_d;
    logic        abort_d;

    // Saturating timer increment, block position and abort qualification.
    always_comb begin
        tmr_d     = (tmr_q == 13'h1fff) ? tmr_q : tmr_q + 13'd1;
        first_d   = (blocks_left_q == blkcnt_q);
        last_d    = (blocks_left_q == 16'd1);
        partial_d = (first_d && (start_pos_q != 11'd0)) ||
                    (last_d && (end_pos_q != FULL_POS)) ||
                    (first_d && mid_start_q) ||
                    (last_d && mid_end_q);
        abort_d   = CMD_ABORT && ((state_q == S_SETUP) || (state_q == S_ARM) ||
                                  (state_q == S_RUN)   || (state_q == S_GAP));
    end

    // Sequencer FSM with registered engine and MCU outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= S_IDLE;
            tmr_q         <= 13'd0;
            en_cnt_q      <= 8'd0;
            en_q          <= 1'b0;
            partial_q     <= 1'b0;
            pstart_q      <= 11'd0;
            pend_q        <= FULL_POS;
            start_mid_q   <= 1'b0;
            end_mid_q     <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            blkcnt_q      <= 16'd0;
            blocks_left_q <= 16'd0;
            start_pos_q   <= 11'd0;
            end_pos_q     <= 11'd0;
            mid_start_q   <= 1'b0;
            mid_end_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // The enable pulse times out on its own, independent of ARM/RUN.
            if (en_q) begin
                en_cnt_q <= en_cnt_q + 8'd1;
                if (en_cnt_q == EN_LAST) en_q <= 1'b0;
            end
            if (abort_d) begin
                en_q    <= 1'b0;
                state_q <= S_WAIT_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (CMD_START) begin
                            blkcnt_q      <= CMD_BLKCNT;
                            blocks_left_q <= CMD_BLKCNT;
                            start_pos_q   <= CMD_START_POS;
                            end_pos_q     <= CMD_END_POS;
                            mid_start_q   <= CMD_MID_START;
                            mid_end_q     <= CMD_MID_END;
                            err_q         <= 1'b0;
                            busy_q        <= 1'b1;
                            tmr_q         <= 13'd0;
                            state_q       <= (CMD_BLKCNT == 16'd0) ? S_FINISH : S_SETUP;
                        end
                    end
                    S_SETUP: begin
                        if (tmr_q == 13'd0) begin
                            partial_q   <= partial_d;
                            pstart_q    <= first_d ? start_pos_q : 11'd0;
                            pend_q      <= last_d ? end_pos_q : FULL_POS;
                            start_mid_q <= first_d && mid_start_q;
                            end_mid_q   <= last_d && mid_end_q;
                        end
                        if (tmr_q == SETTLE_LAST) begin
                            en_q     <= 1'b1;
                            en_cnt_q <= 8'd0;
                            tmr_q    <= 13'd0;
                            state_q  <= S_ARM;
                        end else begin
                            tmr_q <= tmr_d;
                        end
                    end
                    S_ARM: begin
                        if (DMA_STATUS) begin
                            tmr_q   <= 13'd0;
                            state_q <= S_RUN;
                        end else if (tmr_q == ARM_LAST) begin
                            err_q   <= 1'b1;
                            en_q    <= 1'b0;
                            state_q <= S_FINISH;
                        end else begin
                            tmr_q <= tmr_d;
                        end
                    end
                    S_RUN: begin
                        if (!DMA_STATUS) begin
                            blocks_left_q <= blocks_left_q - 16'd1;
                            partial_q     <= 1'b0;
                            tmr_q         <= 13'd0;
                            state_q       <= (blocks_left_q == 16'd1) ? S_FINISH : S_GAP;
                        end else if (tmr_q == RUN_LAST) begin
                            err_q   <= 1'b1;
                            state_q <= S_FINISH;
                        end else begin
                            tmr_q <= tmr_d;
                        end
                    end
                    S_GAP: begin
                        if (tmr_q == GAP_LAST) begin
                            tmr_q   <= 13'd0;
                            state_q <= S_SETUP;
                        end else begin
                            tmr_q <= tmr_d;
                        end
                    end
                    S_WAIT_IDLE: begin
                        if (!DMA_STATUS) state_q <= S_FINISH;
                    end
                    S_FINISH: begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign DMA_EN              = en_q;
    assign DMA_PARTIAL         = partial_q;
    assign DMA_PARTIAL_START   = pstart_q;
    assign DMA_PARTIAL_END     = pend_q;
    assign DMA_START_MID_BLOCK = start_mid_q;
    assign DMA_END_MID_BLOCK   = end_mid_q;
    assign BUSY                = busy_q;
    assign DONE                = done_q;
    assign ERR                 = err_q;
    assign BLOCKS_LEFT         = blocks_left_q;
    assign STATE_DBG           = state_q;

endmodule

// File: tb/tb_sd_dma_seq.sv
// Testbench for sd_dma_seq: a stimulus driver issues MCU commands, an engine
// model answers DMA_EN with a DMA_STATUS burst, and a monitor pops expected
// per-block qualifiers and completion records from scoreboard queues.
`timescale 1ns/1ps
module tb_sd_dma_seq;
    localparam int GAP_CYCLES  = 16;
    localparam int EN_WIDTH    = 4;
    localparam int ARM_TIMEOUT = 64;
    localparam int RUN_TIMEOUT = 4400;

    logic        CLK = 1'b0;
    logic        RST;
    logic        CMD_START, CMD_ABORT;
    logic [15:0] CMD_BLKCNT;
    logic [10:0] CMD_START_POS, CMD_END_POS;
    logic        CMD_MID_START, CMD_MID_END;
    logic        DMA_STATUS;
    logic        DMA_EN, DMA_PARTIAL, DMA_START_MID_BLOCK, DMA_END_MID_BLOCK;
    logic [10:0] DMA_PARTIAL_START, DMA_PARTIAL_END;
    logic        BUSY, DONE, ERR;
    logic [15:0] BLOCKS_LEFT;
    logic [2:0]  STATE_DBG;

    sd_dma_seq #(
        .GAP_CYCLES(GAP_CYCLES), .EN_WIDTH(EN_WIDTH),
        .ARM_TIMEOUT(ARM_TIMEOUT), .RUN_TIMEOUT(RUN_TIMEOUT)
    ) dut (
        .CLK(CLK), .RST(RST), .CMD_START(CMD_START), .CMD_ABORT(CMD_ABORT),
        .CMD_BLKCNT(CMD_BLKCNT), .CMD_START_POS(CMD_START_POS), .CMD_END_POS(CMD_END_POS),
        .CMD_MID_START(CMD_MID_START), .CMD_MID_END(CMD_MID_END), .DMA_STATUS(DMA_STATUS),
        .DMA_EN(DMA_EN), .DMA_PARTIAL(DMA_PARTIAL), .DMA_PARTIAL_START(DMA_PARTIAL_START),
        .DMA_PARTIAL_END(DMA_PARTIAL_END), .DMA_START_MID_BLOCK(DMA_START_MID_BLOCK),
        .DMA_END_MID_BLOCK(DMA_END_MID_BLOCK), .BUSY(BUSY), .DONE(DONE), .ERR(ERR),
        .BLOCKS_LEFT(BLOCKS_LEFT), .STATE_DBG(STATE_DBG)
    );

    // ---------------- clock / reset ----------------
    always #5 CLK = ~CLK;

    // ---------------- scoreboard state ----------------
    // Block record: {not_first, partial, start[11], end[11], smid, emid, blocks_left[16]}
    logic [41:0] blk_q[$];
    // Done record: {latency_mode[2], err, blocks_left[16]}
    //   mode 0: no latency check, 1: ARM_TIMEOUT after EN rise,
    //   2: two cycles after START, 3: one or two cycles after STATUS fall
    logic [18:0] done_q[$];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int start_cyc = 0, rise_cyc = 0, fall_cyc = 0;

    // engine model state
    bit eng_respond = 1'b1;
    int eng_len = 100;
    int eng_ph = 0;
    int eng_k = 0;
    logic eng_en_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        tests++;
        if (act < lo || act > hi) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Reference model: what the engine must be told for block i of n.
    function automatic logic [41:0] blk_rec(input int n, input int i, input int sp,
                                            input int ep, input bit ms, input bit me);
        bit first, last, p;
        int s, e;
        first = (i == 0);
        last  = (i == n - 1);
        p = (first && sp != 0) || (last && ep != 1024) || (first && ms) || (last && me);
        s = first ? sp : 0;
        e = last ? ep : 1024;
        return {!first, p, 11'(s), 11'(e), first && ms, last && me, 16'(n - i)};
    endfunction

    // ---------------- engine model ----------------
    initial begin : engine
        DMA_STATUS = 1'b0;
        forever begin
            @(posedge CLK); #1;
            case (eng_ph)
                0: if (DMA_EN && !eng_en_prev && eng_respond) begin eng_ph = 1; eng_k = 2; end
                1: if (eng_k == 0) begin DMA_STATUS = 1'b1; eng_ph = 2; eng_k = eng_len - 1; end
                   else eng_k--;
                default: if (eng_k == 0) begin DMA_STATUS = 1'b0; eng_ph = 0; end
                         else eng_k--;
            endcase
            eng_en_prev = DMA_EN;
        end
    end

    // ---------------- monitor ----------------
    initial begin : monitor
        logic        en_prev = 1'b0, st_prev = 1'b0;
        logic [24:0] qual, q1 = '0, q2 = '0;
        logic [41:0] eb;
        logic [18:0] ed;
        int          en_w = 0;
        forever begin
            @(negedge CLK);
            cyc++;
            qual = {DMA_PARTIAL, DMA_PARTIAL_START, DMA_PARTIAL_END,
                    DMA_START_MID_BLOCK, DMA_END_MID_BLOCK};
            if (RST) begin
                en_prev = 1'b0; en_w = 0; st_prev = DMA_STATUS; q1 = qual; q2 = qual;
                continue;
            end
            if (CMD_START && !BUSY) start_cyc = cyc;
            if (st_prev && !DMA_STATUS) fall_cyc = cyc;
            if (DMA_EN && !en_prev) begin
                rise_cyc = cyc;
                en_w = 0;
                if (blk_q.size() == 0) begin
                    chk("unexpected_enable", 32'(blk_q.size()), 32'd1);
                end else begin
                    eb = blk_q.pop_front();
                    chk("qualifiers", 32'(qual), 32'(eb[40:16]));
                    chk("qual_lead_1", 32'(q1), 32'(eb[40:16]));
                    chk("qual_lead_2", 32'(q2), 32'(eb[40:16]));
                    chk("blocks_left_at_en", 32'(BLOCKS_LEFT), 32'(eb[15:0]));
                    if (eb[41])
                        chk_range("gap_len", rise_cyc - fall_cyc, GAP_CYCLES + 1, GAP_CYCLES + 5);
                end
            end
            if (DMA_EN) en_w++;
            if (!DMA_EN && en_prev) chk("en_width", 32'(en_w), 32'(EN_WIDTH));
            if (DONE) begin
                if (done_q.size() == 0) begin
                    chk("unexpected_done", 32'(done_q.size()), 32'd1);
                end else begin
                    ed = done_q.pop_front();
                    chk("done_err", 32'(ERR), 32'(ed[16]));
                    chk("done_blocks_left", 32'(BLOCKS_LEFT), 32'(ed[15:0]));
                    chk("done_busy_low", 32'(BUSY), 32'd0);
                    case (ed[18:17])
                        2'd1: chk("arm_timeout_lat", 32'(cyc - rise_cyc), 32'(ARM_TIMEOUT));
                        2'd2: chk("zero_blk_lat", 32'(cyc - start_cyc), 32'd2);
                        2'd3: chk_range("abort_done_lat", cyc - fall_cyc, 1, 2);
                        default: ;
                    endcase
                end
            end
            q2 = q1; q1 = qual;
            en_prev = DMA_EN;
            st_prev = DMA_STATUS;
        end
    end

    // ---------------- driver ----------------
    // kind: 0 normal, 1 mute engine, 2 abort in second block, 3 START while
    // busy, 4 ABORT with START while idle, 5 run timeout (long engine burst)
    task automatic run_cmd(input int n, input int sp, input int ep, input bit ms,
                           input bit me, input int kind, input int len);
        int guard, rises;
        logic st_prev;
        eng_respond = (kind != 1);
        eng_len = len;
        if (n > 0) begin
            if (kind == 1 || kind == 5) blk_q.push_back(blk_rec(n, 0, sp, ep, ms, me));
            else if (kind == 2) for (int i = 0; i < 2; i++) blk_q.push_back(blk_rec(n, i, sp, ep, ms, me));
            else for (int i = 0; i < n; i++) blk_q.push_back(blk_rec(n, i, sp, ep, ms, me));
        end
        if (n == 0)           done_q.push_back({2'd2, 1'b0, 16'd0});
        else if (kind == 1)   done_q.push_back({2'd1, 1'b1, 16'(n)});
        else if (kind == 5)   done_q.push_back({2'd0, 1'b1, 16'(n)});
        else if (kind == 2)   done_q.push_back({2'd3, 1'b0, 16'(n - 1)});
        else                  done_q.push_back({2'd0, 1'b0, 16'd0});

        @(posedge CLK); #1;
        CMD_BLKCNT = 16'(n); CMD_START_POS = 11'(sp); CMD_END_POS = 11'(ep);
        CMD_MID_START = ms; CMD_MID_END = me;
        CMD_START = 1'b1; CMD_ABORT = (kind == 4);
        @(posedge CLK); #1;
        CMD_START = 1'b0; CMD_ABORT = 1'b0;
        @(negedge CLK);
        chk("busy_after_start", 32'(BUSY), 32'd1);
        chk("err_cleared", 32'(ERR), 32'd0);
        chk("blocks_left_load", 32'(BLOCKS_LEFT), 32'(n));

        if (kind == 3) begin
            repeat (10) @(posedge CLK);
            #1; CMD_BLKCNT = 16'd7; CMD_START_POS = 11'd5; CMD_START = 1'b1;
            @(posedge CLK); #1; CMD_START = 1'b0;
        end
        if (kind == 2) begin
            rises = 0; guard = 0; st_prev = DMA_STATUS;
            while (rises < 2 && guard < 20000) begin
                @(negedge CLK); guard++;
                if (DMA_STATUS && !st_prev) rises++;
                st_prev = DMA_STATUS;
            end
            chk("abort_wait_rises", 32'(rises), 32'd2);
            repeat (30) @(posedge CLK);
            #1; CMD_ABORT = 1'b1;
            @(posedge CLK); #1; CMD_ABORT = 1'b0;
        end

        guard = 0;
        while (done_q.size() != 0 && guard < 30000) begin @(negedge CLK); guard++; end
        chk("done_seen", 32'(done_q.size()), 32'd0);
        done_q.delete();
        guard = 0;
        while ((eng_ph != 0 || DMA_STATUS) && guard < 10000) begin @(negedge CLK); guard++; end
        chk("engine_idle", 32'(eng_ph), 32'd0);
        chk("no_pending_blocks", 32'(blk_q.size()), 32'd0);
        blk_q.delete();
        repeat (3) @(negedge CLK);
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        int guard;
        RST = 1'b1; CMD_START = 1'b0; CMD_ABORT = 1'b0; CMD_BLKCNT = '0;
        CMD_START_POS = '0; CMD_END_POS = 11'd1024; CMD_MID_START = 1'b0; CMD_MID_END = 1'b0;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        chk("rst_en", 32'(DMA_EN), 32'd0);
        chk("rst_partial", 32'(DMA_PARTIAL), 32'd0);
        chk("rst_pstart", 32'(DMA_PARTIAL_START), 32'd0);
        chk("rst_pend", 32'(DMA_PARTIAL_END), 32'd1024);
        chk("rst_smid", 32'(DMA_START_MID_BLOCK), 32'd0);
        chk("rst_emid", 32'(DMA_END_MID_BLOCK), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_done", 32'(DONE), 32'd0);
        chk("rst_err", 32'(ERR), 32'd0);
        chk("rst_blocks_left", 32'(BLOCKS_LEFT), 32'd0);
        chk("rst_state_idle", 32'(STATE_DBG), 32'd0);

        run_cmd(3, 0, 1024, 1'b0, 1'b0, 0, 4172);   // full blocks, nominal length
        run_cmd(2, 200, 600, 1'b0, 1'b1, 0, 150);   // start and end offsets over two blocks
        run_cmd(1, 100, 300, 1'b1, 1'b0, 0, 120);   // single block, both offsets
        run_cmd(2, 0, 1024, 1'b0, 1'b0, 1, 0);      // engine never answers
        run_cmd(1, 0, 1024, 1'b0, 1'b0, 0, 80);     // ERR cleared by next command
        run_cmd(5, 0, 1024, 1'b0, 1'b0, 2, 200);    // abort in second block
        run_cmd(0, 0, 1024, 1'b0, 1'b0, 0, 50);     // zero blocks
        run_cmd(2, 10, 1000, 1'b0, 1'b0, 3, 60);    // START while busy ignored
        run_cmd(2, 0, 512, 1'b0, 1'b1, 4, 60);      // ABORT with START while idle
        run_cmd(2, 0, 1024, 1'b0, 1'b0, 5, 4500);   // run timeout

        for (int r = 0; r < 8; r++) begin
            int n, sp, ep, len;
            bit ms, me;
            n   = $urandom_range(1, 4);
            sp  = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(0, 1024);
            ep  = ($urandom_range(0, 2) == 0) ? 1024 : $urandom_range(1, 1024);
            ms  = 1'($urandom_range(0, 1));
            me  = 1'($urandom_range(0, 1));
            len = $urandom_range(20, 200);
            run_cmd(n, sp, ep, ms, me, 0, len);
        end

        // reset in the middle of an enable pulse
        blk_q.push_back(blk_rec(3, 0, 0, 1024, 1'b0, 1'b0));
        eng_respond = 1'b1; eng_len = 100;
        @(posedge CLK); #1;
        CMD_BLKCNT = 16'd3; CMD_START_POS = 11'd0; CMD_END_POS = 11'd1024;
        CMD_MID_START = 1'b0; CMD_MID_END = 1'b0; CMD_START = 1'b1;
        @(posedge CLK); #1; CMD_START = 1'b0;
        guard = 0;
        while (!DMA_EN && guard < 100) begin @(negedge CLK); guard++; end
        chk("rst_test_en_seen", 32'(DMA_EN), 32'd1);
        @(posedge CLK); #1 RST = 1'b1;
        @(posedge CLK); #1 RST = 1'b0;
        @(negedge CLK);
        chk("midrst_en", 32'(DMA_EN), 32'd0);
        chk("midrst_busy", 32'(BUSY), 32'd0);
        chk("midrst_blocks_left", 32'(BLOCKS_LEFT), 32'd0);
        chk("midrst_pend", 32'(DMA_PARTIAL_END), 32'd1024);
        guard = 0;
        while ((eng_ph != 0 || DMA_STATUS) && guard < 1000) begin @(negedge CLK); guard++; end
        repeat (5) @(negedge CLK);
        chk("midrst_no_pending", 32'(blk_q.size() + done_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // ---------------- watchdog ----------------
    initial begin : watchdog
        #600000;
        fails++;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog expired");
    end
endmodule
